layer2_linebuf_ctrl: RTL and testbench
======================================

Name: layer2_linebuf_ctrl

Overview:
Sequencer for the layer-2 convolution line buffer: a chain of shift-register row FIFOs feeding a K x K window.
- Streams one frame of pixels from the feature-map SRAM in raster order, one read per cycle.
- Drives the line-buffer shift enable, tracks the row/column position of each pixel, and flags the cycles when a complete window sits in the buffer.
- Sits between the layer controller (start/done handshake) and the line-buffer/PE datapath (shift_en, window_valid).

Parameters:
IMG_W, 32, frame width in pixels (>= K)
IMG_H, 32, frame height in pixels (>= K)
K, 3, convolution kernel size
ADDR_W, 10, SRAM address width (2^ADDR_W >= IMG_W*IMG_H)
CNT_W, 6, row/column counter width (2^CNT_W > max(IMG_W, IMG_H))

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  begin one frame; sampled only in IDLE
stall  input  1  downstream back-pressure; suspends issuing new reads
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at end of frame
rd_en  output  1  SRAM read strobe
rd_addr  output  ADDR_W  SRAM read address, raster index row*IMG_W+col
shift_en  output  1  line-buffer shift; rd_en delayed exactly 1 cycle (SRAM data valid)
window_valid  output  1  full KxK window present after this shift
win_row  output  CNT_W  top-left row of the valid window
win_col  output  CNT_W  top-left column of the valid window

Behaviour:
- Reset (any time, including mid-frame): state=IDLE; all outputs 0; counters 0; the in-flight read is discarded (shift_en=0 on the next cycle).
- FSM:
  - IDLE: start=1 -> FEED.
  - FEED: rd_en = ~stall.
    - Each cycle with rd_en=1: rd_addr = current index; then advance col, wrapping col=IMG_W-1 -> 0 with row+1.
    - Issuing the read at index IMG_W*IMG_H-1 -> DRAIN.
  - DRAIN: rd_en=0; shift_en carries the last pixel; -> DONE unconditionally, ignoring stall.
  - DONE: done=1 for exactly one cycle; -> IDLE.
- start is ignored outside IDLE. Holding start high in DONE does not retrigger until IDLE is reached, so back-to-back frames have at least 1 idle cycle.
- stall:
  - Affects only new reads.
  - A read issued in the cycle before stall rises still produces shift_en the next cycle.
  - Address and counters freeze while stalled.
- shift_en, in_row and in_col are registered copies of rd_en, row and col (1-cycle SRAM latency).
- window_valid = shift_en && in_row >= K-1 && in_col >= K-1.
- win_row = in_row-(K-1) and win_col = in_col-(K-1) when window_valid=1; 0 otherwise.
- Counters are unsigned, with no overflow inside a frame.
- Timing, no stall, start high at cycle 0:
  - rd_en high cycles 1..N, where N = IMG_W*IMG_H.
  - shift_en high cycles 2..N+1.
  - done at cycle N+2.
  - busy high cycles 1..N+2.
- Window count per frame = (IMG_W-K+1)*(IMG_H-K+1): 900 with defaults.

Test Plan:
- Reset/idle: assert rst mid-simulation -> every output reads 0 in the same cycle; start not asserted -> no rd_en for 100 cycles.
- Nominal frame, IMG_W=5, IMG_H=4, K=3, start pulsed at cycle 0:
  - rd_addr 0..19 on cycles 1..20; shift_en cycles 2..21.
  - window_valid count=6, with (win_row,win_col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - done at cycle 22, busy low at cycle 23.
- Stall: same frame, stall high cycles 5-7 -> rd_addr sequence continuous with no skipped or repeated address; the read issued at cycle 4 shifts at cycle 5; done moves to cycle 25.
- Stall during DRAIN/DONE -> no effect; done still a single-cycle pulse.
- Start while busy pulsed at cycle 10 -> ignored; exactly 20 reads; start held high through DONE -> second frame rd_en begins 2 cycles after done.
- Reset mid-frame at cycle 12 -> IDLE, shift_en=0 next cycle, no done; a fresh start re-reads from address 0.

Source files
------------

// File: rtl/layer2_linebuf_if.sv
// Layer-2 line-buffer sequencer bus.
// master: layer controller + line-buffer/PE side (drives start/stall, observes the rest).
// slave : layer2_linebuf_ctrl (drives busy/done, SRAM read strobe/address, shift/window info).
interface layer2_linebuf_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 6
) ();
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              shift_en;
  logic              window_valid;
  logic [CNT_W-1:0]  win_row;
  logic [CNT_W-1:0]  win_col;

  modport master (
    output start, stall,
    input  busy, done, rd_en, rd_addr, shift_en, window_valid, win_row, win_col
  );

  modport slave (
    input  start, stall,
    output busy, done, rd_en, rd_addr, shift_en, window_valid, win_row, win_col
  );
endinterface

// File: rtl/layer2_linebuf_ctrl.sv
// Line-buffer sequencer for layer-2 convolution: streams one IMG_W x IMG_H frame
// from SRAM in raster order, drives the line-buffer shift and flags full KxK windows.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   start/stall in; busy, done, rd_en, rd_addr, shift_en, window_valid, win_row, win_col out.
module layer2_linebuf_ctrl #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned K      = 3,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 6
) (
  input logic            clk,
  input logic            rst,
  layer2_linebuf_if.slave bus
);

  localparam int unsigned N_PIX = IMG_W * IMG_H;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  row_q, col_q;
  logic              rd_en_c;
  logic              last_rd_c;
  logic              shift_q;
  logic              win_valid_q;
  logic [CNT_W-1:0]  win_row_q, win_col_q;
  logic              win_full_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and read strobe; stall only gates new reads in FEED
  always_comb begin
    state_d   = state_q;
    rd_en_c   = 1'b0;
    last_rd_c = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_FEED;
      S_FEED: begin
        rd_en_c   = ~bus.stall;
        last_rd_c = rd_en_c && (addr_q == ADDR_W'(N_PIX - 1));
        if (last_rd_c) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Raster position of the next read; cleared after the last pixel so the next frame starts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (rd_en_c) begin
      if (last_rd_c) begin
        addr_q <= '0;
        row_q  <= '0;
        col_q  <= '0;
      end else begin
        addr_q <= addr_q + ADDR_W'(1);
        if (col_q == CNT_W'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= row_q + CNT_W'(1);
        end else begin
          col_q <= col_q + CNT_W'(1);
        end
      end
    end
  end

  // The pixel being read completes a window when it is at least K-1 rows and columns in
  assign win_full_c = (row_q >= CNT_W'(K - 1)) && (col_q >= CNT_W'(K - 1));

  // One-cycle SRAM latency: shift and window info follow the read by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      shift_q     <= rd_en_c;
      win_valid_q <= rd_en_c && win_full_c;
      win_row_q   <= (rd_en_c && win_full_c) ? row_q - CNT_W'(K - 1) : '0;
      win_col_q   <= (rd_en_c && win_full_c) ? col_q - CNT_W'(K - 1) : '0;
    end
  end

  assign bus.rd_en        = rd_en_c;
  assign bus.rd_addr      = addr_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.shift_en     = shift_q;
  assign bus.window_valid = win_valid_q;
  assign bus.win_row      = win_row_q;
  assign bus.win_col      = win_col_q;

endmodule

// File: tb/tb_layer2_linebuf_ctrl.sv
// Testbench for layer2_linebuf_ctrl with a 5x4 frame and K=3.
// A pixel-index model predicts every output each cycle; per-frame logs pin cycle timing literally.
module tb_layer2_linebuf_ctrl;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int KK = 3;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer2_linebuf_if #(.ADDR_W(10), .CNT_W(6)) bus ();

  layer2_linebuf_ctrl #(
    .IMG_W(W), .IMG_H(H), .K(KK), .ADDR_W(10), .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: frame progress as "next pixel index" plus cycles elapsed after the last read
  bit m_active, m_sh;
  int m_next, m_after, m_sh_pix;

  function automatic bit e_rd();
    return m_active && (m_next < N) && !bus.stall;
  endfunction
  function automatic bit e_wv();
    return m_sh && (m_sh_pix / W >= KK - 1) && (m_sh_pix % W >= KK - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_sh <= 1'b0; m_next <= 0; m_after <= 0; m_sh_pix <= 0;
    end else begin
      m_sh     <= e_rd();
      m_sh_pix <= m_next;
      if (!m_active) begin
        if (bus.start) begin
          m_active <= 1'b1; m_next <= 0; m_after <= 0;
        end
      end else if (m_next < N) begin
        if (!bus.stall) begin
          m_next <= m_next + 1;
          if (m_next == N - 1) m_after <= 1;
        end
      end else if (m_after == 2) begin
        m_active <= 1'b0;
      end else begin
        m_after <= m_after + 1;
      end
    end
  end

  // Per-frame logs indexed by cycle relative to the start cycle
  bit rd_log[64], sh_log[64], busy_log[64], done_log[64];
  int addr_q[$];
  int win_q[$];
  int t0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 64; i++) begin
      rd_log[i] = 0; sh_log[i] = 0; busy_log[i] = 0; done_log[i] = 0;
    end
    addr_q.delete();
    win_q.delete();
  endtask

  function automatic int first_set(input bit a[64]);
    for (int i = 0; i < 64; i++) if (a[i]) return i;
    return -1;
  endfunction
  function automatic int cnt_set(input bit a[64], input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (a[i]) c++;
    return c;
  endfunction

  // One cycle: compare every output against the model mid-cycle, log, then step past the edge
  task automatic tick();
    int rel;
    int e_addr, e_wrow, e_wcol;
    @(negedge clk);
    e_addr = (m_active && m_next < N) ? m_next : 0;
    e_wrow = e_wv() ? m_sh_pix / W - (KK - 1) : 0;
    e_wcol = e_wv() ? m_sh_pix % W - (KK - 1) : 0;
    chk("rd_en",        int'(bus.rd_en),        int'(e_rd()));
    chk("rd_addr",      int'(bus.rd_addr),      e_addr);
    chk("shift_en",     int'(bus.shift_en),     int'(m_sh));
    chk("window_valid", int'(bus.window_valid), int'(e_wv()));
    chk("win_row",      int'(bus.win_row),      e_wrow);
    chk("win_col",      int'(bus.win_col),      e_wcol);
    chk("busy",         int'(bus.busy),         int'(m_active));
    chk("done",         int'(bus.done),         int'(m_active && m_next == N && m_after == 2));
    rel = cyc - t0;
    if (rel >= 0 && rel < 64) begin
      rd_log[rel] = bus.rd_en; sh_log[rel] = bus.shift_en;
      busy_log[rel] = bus.busy; done_log[rel] = bus.done;
    end
    if (bus.rd_en) addr_q.push_back(int'(bus.rd_addr));
    if (bus.window_valid) win_q.push_back(int'(bus.win_row) * 16 + int'(bus.win_col));
    @(posedge clk);
    #1;
  endtask

  // Start pulse sampled in relative cycle 0
  task automatic begin_frame();
    clear_logs();
    bus.start = 1'b1;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  int exp_win[6] = '{0, 1, 2, 16, 17, 18};

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.stall = 1'b0; t0 = 0;
    clear_logs();
    repeat (3) tick();
    chk("reset_busy",  int'(bus.busy), 0);
    chk("reset_rd_en", int'(bus.rd_en), 0);
    chk("reset_addr",  int'(bus.rd_addr), 0);
    chk("reset_shift", int'(bus.shift_en), 0);
    rst = 1'b0;

    // Idle without start
    clear_logs(); t0 = cyc;
    repeat (100) tick();
    chk("idle_no_reads", addr_q.size(), 0);

    // Nominal frame
    begin_frame();
    repeat (30) tick();
    chk("nom_read_count", addr_q.size(), N);
    for (int i = 0; i < addr_q.size(); i++) chk("nom_addr_seq", addr_q[i], i);
    chk("nom_rd_first",   first_set(rd_log), 1);
    chk("nom_rd_cnt",     cnt_set(rd_log, 1, 20), 20);
    chk("nom_sh_first",   first_set(sh_log), 2);
    chk("nom_sh_cnt",     cnt_set(sh_log, 2, 21), 20);
    chk("nom_done_cycle", first_set(done_log), 22);
    chk("nom_done_cnt",   cnt_set(done_log, 0, 63), 1);
    chk("nom_busy_22",    int'(busy_log[22]), 1);
    chk("nom_busy_23",    int'(busy_log[23]), 0);
    chk("nom_win_count",  win_q.size(), 6);
    for (int i = 0; i < 6 && i < win_q.size(); i++) chk("nom_win_pos", win_q[i], exp_win[i]);

    // Stall for cycles 5..7
    begin_frame();
    for (int r = 1; r < 36; r++) begin
      bus.stall = (r >= 5 && r <= 7);
      tick();
    end
    bus.stall = 1'b0;
    chk("stall_read_count", addr_q.size(), N);
    for (int i = 0; i < addr_q.size(); i++) chk("stall_addr_seq", addr_q[i], i);
    chk("stall_shift_at_5", int'(sh_log[5]), 1);
    chk("stall_rd_5_7",     cnt_set(rd_log, 5, 7), 0);
    chk("stall_done_cycle", first_set(done_log), 25);

    // Stall over DRAIN and DONE
    begin_frame();
    for (int r = 1; r < 30; r++) begin
      bus.stall = (r >= 21 && r <= 23);
      tick();
    end
    bus.stall = 1'b0;
    chk("drain_stall_done_cycle", first_set(done_log), 22);
    chk("drain_stall_done_cnt",   cnt_set(done_log, 0, 63), 1);

    // Start while busy, then start held through DONE
    begin_frame();
    for (int r = 1; r < 50; r++) begin
      bus.start = (r == 10) || (r >= 20 && r <= 23);
      tick();
    end
    bus.start = 1'b0;
    chk("busy_start_reads",  cnt_set(rd_log, 1, 22), 20);
    chk("busy_start_done",   first_set(done_log), 22);
    chk("retrigger_gap_23",  int'(rd_log[23]), 0);
    chk("retrigger_rd_24",   int'(rd_log[24]), 1);
    chk("retrigger_addr0",   addr_q.size() > 20 ? addr_q[20] : -1, 0);

    // Reset at cycle 12 of a frame, then a fresh frame
    begin_frame();
    for (int r = 1; r < 30; r++) begin
      rst = (r == 12);
      tick();
    end
    rst = 1'b0;
    chk("rstmid_no_done",  cnt_set(done_log, 0, 63), 0);
    chk("rstmid_shift_13", int'(sh_log[13]), 0);
    chk("rstmid_busy_13",  int'(busy_log[13]), 0);
    chk("rstmid_reads",    addr_q.size(), 11);
    begin_frame();
    repeat (30) tick();
    chk("fresh_first_addr", addr_q.size() > 0 ? addr_q[0] : -1, 0);
    chk("fresh_read_count", addr_q.size(), N);
    chk("fresh_done_cycle", first_set(done_log), 22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
